// File: rtl/if_stage.sv
// Instruction fetch stage: one word per cycle from imem, with a one-entry skid
// buffer for decode stalls and branch redirect from execute.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    hold_insn_d = hold_insn_q;
    hold_pc_d   = hold_pc_q;

    if (branch_taken) begin
      // Redirect wins over everything; the buffer is emptied simply by leaving HOLD.
      pc_d       = branch_target & 32'hFFFF_FFFC;
      ir_d       = NOP_INSN;
      ir_valid_d = 1'b0;
      state_d    = S_REQ;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              hold_insn_d = imem_rdata;
              hold_pc_d   = pc_q;
              state_d     = S_HOLD;
            end else begin
              ir_d       = imem_rdata;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
            end
          end else if (!stall) begin
            ir_d       = NOP_INSN;
            ir_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ir_d       = hold_insn_q;
            ir_pc_d    = hold_pc_q;
            ir_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSN;
      ir_pc_q    <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Buffer contents are only meaningful in HOLD, so they need no reset.
  always_ff @(posedge clk) begin
    hold_insn_q <= hold_insn_d;
    hold_pc_q   <= hold_pc_d;
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues expected fetches, the monitor
// pops one whenever decode accepts a valid ir (ir_valid=1 and stall=0).
module tb_if_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ XORK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_q.push_back({a, a ^ XORK});
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && ir_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ir: got pc %h insn %h expected none", ir_pc, ir);
      end else begin
        e = exp_q.pop_front();
        check("ir_pc", ir_pc, e[63:32]);
        check("ir", ir, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // Reset state
    tick; tick;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ir", ir, NOP);
    check("rst_ir_pc", ir_pc, 32'h0);
    check("rst_valid", {31'b0, ir_valid}, 32'd0);

    // Zero-wait streaming, ack tied high (ack in IDLE must be ignored)
    rst = 1'b0; imem_ack = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("idle_ack_ignored", {31'b0, ir_valid}, 32'd0);
    for (int i = 0; i < 6; i++) expect_fetch(32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      tick;
      check("stream_valid", {31'b0, ir_valid}, 32'd1);
      check("stream_addr", imem_addr, 32'(4 * (i + 1)));
    end
    imem_ack = 1'b0;

    // Ack every third cycle: two bubbles, address held
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        tick;
        check("wait_valid", {31'b0, ir_valid}, 32'd0);
        check("wait_ir", ir, NOP);
        check("wait_addr", imem_addr, 32'(24 + 4 * k));
        check("wait_req", {31'b0, imem_req}, 32'd1);
      end
      imem_ack = 1'b1;
      expect_fetch(32'(24 + 4 * k));
      tick;
      imem_ack = 1'b0;
      check("wait_done_valid", {31'b0, ir_valid}, 32'd1);
    end

    // Stall for 3 cycles coinciding with the ack at 0x8
    branch_taken = 1'b1; branch_target = 32'h8;
    tick;
    branch_taken = 1'b0;
    check("br8_addr", imem_addr, 32'h8);
    check("br8_valid", {31'b0, ir_valid}, 32'd0);
    stall = 1'b1; imem_ack = 1'b1;
    tick;
    check("hold_req", {31'b0, imem_req}, 32'd0);
    check("hold_valid", {31'b0, ir_valid}, 32'd0);
    for (int j = 0; j < 2; j++) begin
      tick;
      check("hold_req_stay", {31'b0, imem_req}, 32'd0);
      check("hold_addr", imem_addr, 32'hC);
      check("hold_valid_stay", {31'b0, ir_valid}, 32'd0);
    end
    stall = 1'b0; imem_ack = 1'b0;
    expect_fetch(32'h8);
    tick;
    check("unhold_valid", {31'b0, ir_valid}, 32'd1);
    check("unhold_req", {31'b0, imem_req}, 32'd1);
    check("unhold_addr", imem_addr, 32'hC);
    imem_ack = 1'b1;
    expect_fetch(32'hC);
    tick;
    imem_ack = 1'b0; stall = 1'b1;
    tick;
    check("stall_hold_valid", {31'b0, ir_valid}, 32'd1);
    check("stall_hold_pc", ir_pc, 32'hC);
    check("stall_hold_addr", imem_addr, 32'h10);
    stall = 1'b0;
    tick;
    check("post_stall_bubble", {31'b0, ir_valid}, 32'd0);

    // Branch during HOLD with a same-cycle ack
    stall = 1'b1; imem_ack = 1'b1;
    tick;
    check("hold2_req", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    tick;
    branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    check("br_hold_addr", imem_addr, 32'h100);
    check("br_hold_valid", {31'b0, ir_valid}, 32'd0);
    check("br_hold_ir", ir, NOP);
    check("br_hold_req", {31'b0, imem_req}, 32'd1);
    tick;
    check("buf_dropped", {31'b0, ir_valid}, 32'd0);
    check("buf_dropped_addr", imem_addr, 32'h100);
    imem_ack = 1'b1;
    expect_fetch(32'h100);
    tick;
    imem_ack = 1'b0;
    check("after_br_addr", imem_addr, 32'h104);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick;
    branch_taken = 1'b0;
    check("wrap_start", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    expect_fetch(32'hFFFF_FFFC);
    tick;
    check("wrap_addr", imem_addr, 32'h0);
    expect_fetch(32'h0);
    tick;
    imem_ack = 1'b0;
    check("wrap_next", imem_addr, 32'h4);
    tick;

    // Asynchronous reset mid-request
    stall = 1'b1; imem_ack = 1'b1;
    tick;
    stall = 1'b0; imem_ack = 1'b0;
    expect_fetch(32'h4);
    tick;
    stall = 1'b1;
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    check("pre_rst_valid", {31'b0, ir_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_ir", ir, NOP);
    check("arst_valid", {31'b0, ir_valid}, 32'd0);
    check("arst_ir_pc", ir_pc, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    exp_q.delete();  // the presented word was flushed by reset
    stall = 1'b0;
    tick;
    check("arst_hold_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b0;
    check("rel_idle_req", {31'b0, imem_req}, 32'd0);
    tick;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    expect_fetch(32'h0);
    tick;
    imem_ack = 1'b0;
    tick;
    tick;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013 (ADDI x0,x0,0), is the bubble word driven on ir.
REQ-003 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  is an asynchronous, active-high reset.
REQ-005 imem_req  output  1  means a fetch request is valid at imem_addr.
REQ-006 imem_addr  output  32  is the fetch address, always word-aligned.
REQ-007 imem_ack  input  1  means imem_rdata holds the word for imem_addr in this cycle.
REQ-008 imem_rdata  input  32  is the instruction word returned by memory.
REQ-009 stall  input  1  means the decode stage cannot accept a new instruction this cycle.
REQ-010 branch_taken  input  1  is a redirect request from the execute stage.
REQ-011 branch_target  input  32  is the redirect address.
REQ-012 ir  output  32  is the registered instruction word presented to the decode stage.
REQ-013 ir_pc  output  32  is the registered address of ir.
REQ-014 ir_valid  output  1  means ir/ir_pc hold a real instruction and not a bubble.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and HOLD; imem_req SHALL be 1 only in REQ.
REQ-016 IDLE SHALL go to REQ on the next clock edge with no other side effect.
REQ-017 The internal register pc SHALL drive imem_addr, and imem_addr SHALL be constant while imem_req=1 and imem_ack=0, unless branch_taken=1.
REQ-018 In REQ with ack=1 and stall=0: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+4, and the FSM SHALL stay in REQ (one instruction per cycle at zero wait states).
REQ-019 In REQ with ack=1 and stall=1: imem_rdata/pc SHALL be captured into a one-entry holding buffer, pc<=pc+4, the FSM SHALL go to HOLD, and ir/ir_pc/ir_valid SHALL hold.
REQ-020 In REQ with ack=0 and stall=0: ir<=NOP_INSN and ir_valid<=0; ir_pc SHALL hold.
REQ-021 With stall=1 in any state: ir, ir_pc and ir_valid SHALL hold their values.
REQ-022 In HOLD: imem_req=0; when stall=0, the buffer SHALL move to ir/ir_pc, ir_valid<=1 and the FSM SHALL go to REQ; when stall=1, the FSM SHALL stay in HOLD.
REQ-023 branch_taken=1 SHALL take priority over stall and ack in every state: pc<={branch_target[31:2],2'b00}, ir<=NOP_INSN, ir_valid<=0, the holding buffer SHALL be discarded, the FSM SHALL go to REQ, and any same-cycle imem_rdata SHALL be dropped.
REQ-024 The low two bits of branch_target SHALL be ignored; no exception is raised.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Each fetched instruction SHALL appear on ir with ir_valid=1 exactly once, in address order, unless it is flushed by branch_taken.
REQ-027 imem_ack received while imem_req=0 SHALL be ignored.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, ir=NOP_INSN, ir_pc=0, ir_valid=0, imem_req=0, and the holding buffer SHALL be empty.
REQ-029 rst asserted mid-operation SHALL immediately abort any request and discard any buffered or in-flight word.
REQ-030 The first request after rst is released SHALL issue RESET_PC in the second rising edge's cycle (IDLE then REQ).

Verification
REQ-031 Reset release with ack tied to 1, stall=0, and memory returning addr^32'hA5A5_0000 -> ir_pc sequence 0,4,8,... with ir_valid=1 every cycle and matching data.
REQ-032 ack asserted every third cycle -> two NOP bubbles (ir_valid=0) between valid instructions, with imem_addr held stable while waiting.
REQ-033 stall=1 for 3 cycles coinciding with an ack at 0x8 -> FSM in HOLD, imem_req=0; 0x8 appears once after stall drops, and fetch resumes at 0xC.
REQ-034 branch_taken=1 with branch_target=32'h0000_0102 during HOLD and ack -> buffer dropped, next imem_addr=0x100, ir_valid=0 for that cycle.
REQ-035 pc preloaded via branch_target to 32'hFFFF_FFFC -> next fetch at 32'h0000_0000.
REQ-036 rst pulse asserted asynchronously mid-request -> imem_req drops in the same cycle, and ir=32'h0000_0013 with ir_valid=0.
